// File: rtl/flow_quant_ctrl_if.sv
// Stream, table-config and divider-side signals of the quantization controller.
// The controller uses the slave modport; the driver/divider side uses master.
interface flow_quant_ctrl_if #(
  parameter int N = 2
);
  logic            en;
  logic            in_valid;
  logic [N*16-1:0] in_data;
  logic            in_sob;
  logic            in_eob;
  logic            in_sof;

  logic            cfg_we;
  logic            cfg_tbl;
  logic [5:0]      cfg_addr;
  logic [9:0]      cfg_data;

  logic            div_valid;
  logic [N*16-1:0] div_data;
  logic [N*10-1:0] div_denom;
  logic            div_sob;
  logic            div_eob;
  logic            div_sof;
  logic            err;

  modport master (
    output en, in_valid, in_data,
    output in_sob, in_eob, in_sof,
    output cfg_we, cfg_tbl,
    output cfg_addr, cfg_data,
    input  div_valid, div_data,
    input  div_denom, div_sob,
    input  div_eob, div_sof, err
  );

  modport slave (
    input  en, in_valid, in_data,
    input  in_sob, in_eob, in_sof,
    input  cfg_we, cfg_tbl,
    input  cfg_addr, cfg_data,
    output div_valid, div_data,
    output div_denom, div_sob,
    output div_eob, div_sof, err
  );
endinterface

// File: rtl/flow_quant_ctrl.sv
// JPEG quantization controller: tracks position/component, looks up denominators.
// Define FLOW_QUANT_ZIGZAG_EN when the input stream arrives in zigzag order.
module flow_quant_ctrl #(
  parameter int N         = 2,
  parameter int LUMA_BLKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  flow_quant_ctrl_if.slave   bus
);

  localparam int B  = 64 / N;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int CW = $clog2(LUMA_BLKS + 2);

`ifdef FLOW_QUANT_ZIGZAG_EN
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };
`endif

  logic            acc;
  logic [BW-1:0]   idx;
  logic            last;
  logic            chroma;
  logic            bad;

  logic [BW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   comp_q, comp_d, comp_nx;
  logic            blk_q, blk_d;
  logic            err_q, err_d;

  logic [9:0]      luma_q   [64];
  logic [9:0]      chroma_q [64];

  logic            valid_q;
  logic [N*16-1:0] data_q;
  logic [N*10-1:0] denom_q, denom_d;
  logic            sob_q, eob_q, sof_q;

  assign acc  = bus.in_valid & bus.en;
  assign idx  = bus.in_sob ? '0 : cnt_q;
  assign last = (idx == BW'(B - 1));

  always_comb begin
    comp_nx = comp_q;
    if (bus.in_sob) begin
      if (bus.in_sof)
        comp_nx = '0;
      else if (comp_q == CW'(LUMA_BLKS + 1))
        comp_nx = '0;
      else
        comp_nx = comp_q + 1'b1;
    end
  end

  assign chroma = (comp_nx >= CW'(LUMA_BLKS));

  assign bad = (bus.in_eob & ~last)
             | (last & ~bus.in_eob)
             | (~bus.in_sob & ~blk_q)
             | (bus.in_sob & blk_q);

  always_comb begin
    cnt_d  = cnt_q;
    comp_d = comp_q;
    blk_d  = blk_q;
    err_d  = err_q;
    if (acc) begin
      cnt_d  = last ? '0 : idx + 1'b1;
      comp_d = comp_nx;
      unique case (1'b1)
        bus.in_eob: blk_d = 1'b0;
        bus.in_sob: blk_d = 1'b1;
        default:    blk_d = blk_q;
      endcase
      if (bad)
        err_d = 1'b1;
      else if (bus.in_sof)
        err_d = 1'b0;
    end
  end

  // Lookup reads the current table contents, so a same-cycle write is seen next beat
  always_comb begin
    denom_d = '0;
    for (int i = 0; i < N; i++) begin
      logic [5:0] a;
      logic [9:0] ent;
      a = 6'(int'(idx) * N + i);
`ifdef FLOW_QUANT_ZIGZAG_EN
      a = 6'(ZZ[a]);
`endif
      ent = chroma ? chroma_q[a] : luma_q[a];
      denom_d[i*10 +: 10] = (ent == 10'd0) ? 10'd1 : ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) begin
        luma_q[k]   <= 10'd1;
        chroma_q[k] <= 10'd1;
      end
    end else if (bus.cfg_we) begin
      if (bus.cfg_tbl)
        chroma_q[bus.cfg_addr] <= bus.cfg_data;
      else
        luma_q[bus.cfg_addr]   <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      comp_q <= CW'(LUMA_BLKS + 1);
      blk_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      comp_q <= comp_d;
      blk_q  <= blk_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      denom_q <= {N{10'd1}};
      sob_q   <= 1'b0;
      eob_q   <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      if (bus.en)
        valid_q <= bus.in_valid;
      if (acc) begin
        data_q  <= bus.in_data;
        denom_q <= denom_d;
        sob_q   <= bus.in_sob;
        eob_q   <= bus.in_eob;
        sof_q   <= bus.in_sof;
      end
    end
  end

  assign bus.div_valid = valid_q;
  assign bus.div_data  = data_q;
  assign bus.div_denom = denom_q;
  assign bus.div_sob   = sob_q;
  assign bus.div_eob   = eob_q;
  assign bus.div_sof   = sof_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_flow_quant_ctrl.sv
// Scoreboard bench for flow_quant_ctrl: directed MCU scenarios plus random blocks,
// checked against a queue-based reference model of the framing/table rules.
module tb_flow_quant_ctrl;

  localparam int N  = 2;
  localparam int LB = 4;
  localparam int B  = 64 / N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flow_quant_ctrl_if #(.N(N)) bus ();

  flow_quant_ctrl #(.N(N), .LUMA_BLKS(LB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [N*16-1:0] data;
    logic [N*10-1:0] denom;
    logic            sob, eob, sof, err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int luma [64];
  int chrm [64];
  int m_pos;
  int m_comp;
  bit m_blk;
  bit m_err;

`ifdef FLOW_QUANT_ZIGZAG_EN
  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };
`endif

  function automatic int lut(input int a);
`ifdef FLOW_QUANT_ZIGZAG_EN
    return zz[a];
`else
    return a;
`endif
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: beat position, MCU component, framing flag and sticky error
  task automatic model(input logic [N*16-1:0] d, input bit sob,
                       input bit eob, input bit sof);
    int   idx;
    int   v;
    bit   e_now;
    exp_t e;
    idx = sob ? 0 : m_pos;
    if (sob) m_comp = sof ? 0 : (m_comp + 1) % (LB + 2);
    e_now = (eob && idx != B - 1) || (idx == B - 1 && !eob) ||
            (!sob && !m_blk) || (sob && m_blk);
    if (sob) m_blk = 1'b1;
    if (eob) m_blk = 1'b0;
    if (e_now) m_err = 1'b1;
    else if (sof) m_err = 1'b0;
    m_pos = (idx + 1) % B;
    e.data = d;
    e.sob  = sob;
    e.eob  = eob;
    e.sof  = sof;
    e.err  = m_err;
    e.denom = '0;
    for (int i = 0; i < N; i++) begin
      v = (m_comp < LB) ? luma[lut(idx * N + i)] : chrm[lut(idx * N + i)];
      if (v == 0) v = 1;
      e.denom[i*10 +: 10] = 10'(v);
    end
    q.push_back(e);
  endtask

  task automatic cyc(input bit v, input bit e, input bit sob, input bit eob,
                     input bit sof, input bit we = 1'b0, input bit tbl = 1'b0,
                     input int addr = 0, input int val = 0);
    logic [N*16-1:0] d;
    @(negedge clk);
    d = (N*16)'($urandom);
    bus.en       = e;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sob   = sob;
    bus.in_eob   = eob;
    bus.in_sof   = sof;
    bus.cfg_we   = we;
    bus.cfg_tbl  = tbl;
    bus.cfg_addr = 6'(addr);
    bus.cfg_data = 10'(val);
    if (v && e) model(d, sob, eob, sof);
    if (we) begin
      if (tbl) chrm[addr] = val;
      else     luma[addr] = val;
    end
  endtask

  task automatic wr(input bit tbl, input int addr, input int val);
    cyc(1'b0, 1'b1, bit'($urandom), bit'($urandom), bit'($urandom),
        1'b1, tbl, addr, val);
  endtask

  task automatic blk(input bit sof, input int bad = -1, input int stall_at = -1,
                     input int we_beat = -1, input bit tbl = 1'b0,
                     input int addr = 0, input int val = 0, input bit rnd = 1'b0);
    bit sob, eob;
    for (int j = 0; j < B; j++) begin
      if (j == stall_at)
        repeat (3) cyc(1'b1, 1'b0, bit'($urandom), bit'($urandom), bit'($urandom));
      if (rnd && $urandom_range(0, 7) == 0)
        cyc(1'b1, 1'b0, bit'($urandom), bit'($urandom), bit'($urandom));
      sob = (j == 0);
      eob = (bad < 0) ? (j == B - 1) : (j == bad);
      if (j == we_beat)
        cyc(1'b1, 1'b1, sob, eob, sof && sob, 1'b1, tbl, addr, val);
      else
        cyc(1'b1, 1'b1, sob, eob, sof && sob);
    end
  endtask

  // Monitor: pops one expectation per accepted beat, checks hold on stalls
  logic [N*16-1:0] s_data;
  logic [N*10-1:0] s_denom;
  logic            s_valid, s_err;

  initial begin
    bit en_e, v_e;
    exp_t e;
    @(posedge rst_n);
    #1;
    s_data  = bus.div_data;
    s_denom = bus.div_denom;
    s_valid = bus.div_valid;
    s_err   = bus.err;
    forever begin
      @(posedge clk);
      en_e = bus.en;
      v_e  = bus.in_valid;
      #1;
      if (en_e) begin
        check("div_valid", 64'(bus.div_valid), 64'(v_e));
        if (v_e) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got unexpected beat want none at %0t", $time);
          end else begin
            e = q.pop_front();
            check("div_data",  64'(bus.div_data),  64'(e.data));
            check("div_denom", 64'(bus.div_denom), 64'(e.denom));
            check("div_sob",   64'(bus.div_sob),   64'(e.sob));
            check("div_eob",   64'(bus.div_eob),   64'(e.eob));
            check("div_sof",   64'(bus.div_sof),   64'(e.sof));
            check("err",       64'(bus.err),       64'(e.err));
          end
        end
      end else begin
        check("hold_data",  64'(bus.div_data),  64'(s_data));
        check("hold_denom", 64'(bus.div_denom), 64'(s_denom));
        check("hold_valid", 64'(bus.div_valid), 64'(s_valid));
        check("hold_err",   64'(bus.err),       64'(s_err));
      end
      s_data  = bus.div_data;
      s_denom = bus.div_denom;
      s_valid = bus.div_valid;
      s_err   = bus.err;
    end
  end

  initial begin
    bit sf;
    int bd;
    for (int k = 0; k < 64; k++) begin
      luma[k] = 1;
      chrm[k] = 1;
    end
    m_pos  = 0;
    m_comp = LB + 1;
    m_blk  = 1'b0;
    m_err  = 1'b0;
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sob   = 1'b0;
    bus.in_eob   = 1'b0;
    bus.in_sof   = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_tbl  = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.div_valid), 64'd0);
    check("rst_err",   64'(bus.err),       64'd0);
    check("rst_data",  64'(bus.div_data),  64'd0);
    check("rst_denom", 64'(bus.div_denom), 64'({N{10'd1}}));
    check("rst_sob",   64'(bus.div_sob),   64'd0);
    rst_n = 1'b1;

    blk(1'b0);
    wr(1'b0, 5, 16);
    wr(1'b1, 5, 99);
    for (int b = 0; b < 2 * (LB + 2); b++) blk(b == 0);
    wr(1'b0, 0, 0);
    blk(1'b0);
    blk(.sof(1'b0), .we_beat(1), .tbl(1'b0), .addr(3), .val(40));
    blk(1'b0);
    blk(.sof(1'b1), .bad(20));
    blk(1'b0);
    blk(1'b1);
    blk(.sof(1'b0), .stall_at(10));
    wr(1'b0, 8, 7);
    blk(1'b1);

    repeat (40) begin
      repeat ($urandom_range(0, 3))
        wr(bit'($urandom), $urandom_range(0, 63),
           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 1023));
      sf = ($urandom_range(0, 5) == 0);
      bd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, B - 1) : -1;
      blk(.sof(sf), .bad(bd), .rnd(1'b1));
      repeat ($urandom_range(0, 2))
        cyc(1'b0, bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom));
    end

    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
